// File: rtl/register_bus_arbiter.sv
// Round-robin arbiter that shares one register-adapter command port among several requesters.
// Reads are tagged with the requester index so the fixed-latency read_valid is routed back
// to the requester that issued the read.
module register_bus_arbiter #(
  parameter int unsigned REQUESTERS   = 2,
  parameter int unsigned LATENCY      = 1,
  parameter int unsigned ADDRESSWIDTH = 4,
  // Derived from REQUESTERS; leave at its default.
  parameter int unsigned IDWIDTH      = $clog2(REQUESTERS)
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [REQUESTERS-1:0]                     req_read,
  input  logic [REQUESTERS-1:0]                     req_write,
  input  logic [REQUESTERS-1:0][ADDRESSWIDTH-1:0]   req_address,
  input  logic [REQUESTERS-1:0][31:0]               req_data_in,
  output logic [REQUESTERS-1:0]                     req_waitrequest,
  output logic [REQUESTERS-1:0]                     req_read_valid,
  output logic [31:0]                               req_data_out,
  output logic                                      read,
  output logic                                      write,
  output logic [ADDRESSWIDTH-1:0]                   address,
  output logic [31:0]                               data_in,
  input  logic                                      read_valid,
  input  logic [31:0]                               data_out,
  output logic                                      tag_error
);

  logic [REQUESTERS-1:0]               active;
  logic [REQUESTERS-1:0]               grant_oh;
  logic                                grant_valid;
  logic [IDWIDTH-1:0]                  grant_id;
  logic [IDWIDTH-1:0]                  rr_ptr_q, rr_ptr_d;
  logic                                issue_read;
  logic [ADDRESSWIDTH-1:0]             addr_hold_q;
  logic [31:0]                         data_hold_q;
  logic [LATENCY-1:0]                  tag_valid_q;
  logic [LATENCY-1:0][IDWIDTH-1:0]     tag_id_q;
  logic                                tag_error_q, tag_error_d;

  assign active = req_read | req_write;

  // Grant search: first active requester scanning upward from rr_ptr, wrapping at REQUESTERS.
  always_comb begin
    logic [IDWIDTH:0] sum;
    grant_valid = 1'b0;
    grant_id    = '0;
    sum         = '0;
    for (int unsigned k = 0; k < REQUESTERS; k++) begin
      sum = {1'b0, rr_ptr_q} + (IDWIDTH + 1)'(k);
      if (sum >= (IDWIDTH + 1)'(REQUESTERS)) begin
        sum = sum - (IDWIDTH + 1)'(REQUESTERS);
      end
      // No grants while reset is held so every active requester stalls.
      if (!grant_valid && reset && active[sum[IDWIDTH-1:0]]) begin
        grant_valid = 1'b1;
        grant_id    = sum[IDWIDTH-1:0];
      end
    end
  end

  // Command path, stall signals and next round-robin pointer.
  always_comb begin
    grant_oh        = '0;
    write           = 1'b0;
    issue_read      = 1'b0;
    address         = addr_hold_q;
    data_in         = data_hold_q;
    rr_ptr_d        = rr_ptr_q;
    if (grant_valid) begin
      grant_oh   = REQUESTERS'(1) << grant_id;
      write      = req_write[grant_id];
      // Write wins; a simultaneous read is consumed without a tag.
      issue_read = req_read[grant_id] & ~req_write[grant_id];
      address    = req_address[grant_id];
      data_in    = req_data_in[grant_id];
      rr_ptr_d   = (grant_id == IDWIDTH'(REQUESTERS - 1)) ? '0 : grant_id + IDWIDTH'(1);
    end
    read            = issue_read;
    req_waitrequest = active & ~grant_oh;
  end

  // Return path: route read_valid by the oldest tag; a response without a tag is an error.
  always_comb begin
    req_read_valid = '0;
    if (read_valid && tag_valid_q[LATENCY-1]) begin
      req_read_valid = REQUESTERS'(1) << tag_id_q[LATENCY-1];
    end
    req_data_out = data_out;
    tag_error_d  = tag_error_q | (read_valid & ~tag_valid_q[LATENCY-1]);
  end

  assign tag_error = tag_error_q;

  // Pointer, held command fields and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      addr_hold_q <= '0;
      data_hold_q <= '0;
      tag_error_q <= 1'b0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_error_q <= tag_error_d;
      if (grant_valid) begin
        addr_hold_q <= address;
        data_hold_q <= data_in;
      end
    end
  end

  // Tag shift register, one stage per cycle of adapter read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid_q <= '0;
      tag_id_q    <= '0;
    end else begin
      tag_valid_q[0] <= issue_read;
      tag_id_q[0]    <= grant_id;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_valid_q[i] <= tag_valid_q[i-1];
        tag_id_q[i]    <= tag_id_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_register_bus_arbiter.sv
// Directed bench for register_bus_arbiter with three requesters and read latency 2.
module tb_register_bus_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned LAT  = 2;
  localparam int unsigned AW   = 4;

  logic                      clk;
  logic                      reset;
  logic [NREQ-1:0]           req_read;
  logic [NREQ-1:0]           req_write;
  logic [NREQ-1:0][AW-1:0]   req_address;
  logic [NREQ-1:0][31:0]     req_data_in;
  logic [NREQ-1:0]           req_waitrequest;
  logic [NREQ-1:0]           req_read_valid;
  logic [31:0]               req_data_out;
  logic                      read;
  logic                      write;
  logic [AW-1:0]             address;
  logic [31:0]               data_in;
  logic                      read_valid;
  logic [31:0]               data_out;
  logic                      tag_error;

  int n_cmp;
  int n_err;

  register_bus_arbiter #(
    .REQUESTERS   (NREQ),
    .LATENCY      (LAT),
    .ADDRESSWIDTH (AW)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_address     (req_address),
    .req_data_in     (req_data_in),
    .req_waitrequest (req_waitrequest),
    .req_read_valid  (req_read_valid),
    .req_data_out    (req_data_out),
    .read            (read),
    .write           (write),
    .address         (address),
    .data_in         (data_in),
    .read_valid      (read_valid),
    .data_out        (data_out),
    .tag_error       (tag_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    req_read   = '0;
    req_write  = '0;
    read_valid = 1'b0;
    data_out   = '0;
  endtask

  initial begin
    int g;
    logic [2:0] exp_wait;
    n_cmp       = 0;
    n_err       = 0;
    reset       = 1'b0;
    req_address = '0;
    req_data_in = '0;
    set_idle();

    // Reset: active requester stalls, nothing issued, holds cleared.
    req_write      = 3'b001;
    req_address[0] = 4'hF;
    req_data_in[0] = 32'hDEAD;
    #1;
    chk("rst_wait", req_waitrequest, 3'b001);
    chk("rst_write", write, 1'b0);
    chk("rst_read", read, 1'b0);
    chk("rst_addr", address, 4'h0);
    chk("rst_data", data_in, 32'h0);
    chk("rst_rvalid", req_read_valid, 3'b000);
    chk("rst_tagerr", tag_error, 1'b0);

    // Single requester read, response two cycles later.
    @(negedge clk);
    reset = 1'b1;
    set_idle();
    req_read       = 3'b010;
    req_address[1] = 4'd3;
    #1;
    chk("single_read", read, 1'b1);
    chk("single_write", write, 1'b0);
    chk("single_addr", address, 4'd3);
    chk("single_wait", req_waitrequest, 3'b000);
    @(negedge clk);
    set_idle();
    #1;
    chk("idle_read", read, 1'b0);
    chk("idle_addr_hold", address, 4'd3);
    chk("idle_rvalid", req_read_valid, 3'b000);
    @(negedge clk);
    read_valid = 1'b1;
    data_out   = 32'hA5A5_0003;
    #1;
    chk("single_rvalid", req_read_valid, 3'b010);
    chk("single_rdata", req_data_out, 32'hA5A5_0003);
    chk("single_tagerr", tag_error, 1'b0);
    @(negedge clk);
    set_idle();
    #1;
    chk("single_rvalid_end", req_read_valid, 3'b000);

    // Contention: rr_ptr is 2, so grants go 2,0,1,2 (wraps 2 -> 0).
    req_address[0] = 4'd8;
    req_address[1] = 4'd9;
    req_address[2] = 4'd10;
    req_data_in[0] = 32'h100;
    req_data_in[1] = 32'h101;
    req_data_in[2] = 32'h102;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      req_write = 3'b111;
      #1;
      g        = (2 + k) % 3;
      exp_wait = 3'b111 & ~(3'b001 << g);
      chk("cont_addr", address, 64'(8 + g));
      chk("cont_data", data_in, 64'(32'h100 + g));
      chk("cont_wait", req_waitrequest, exp_wait);
      chk("cont_write", write, 1'b1);
    end

    // Pipelined reads to ids 0,1,0 with responses overlapping new commands.
    @(negedge clk);
    set_idle();
    req_read       = 3'b001;
    req_address[0] = 4'd1;
    #1;
    chk("pipe0_read", read, 1'b1);
    chk("pipe0_addr", address, 4'd1);
    chk("pipe0_wait", req_waitrequest, 3'b000);
    @(negedge clk);
    req_read       = 3'b010;
    req_address[1] = 4'd2;
    #1;
    chk("pipe1_read", read, 1'b1);
    chk("pipe1_addr", address, 4'd2);
    @(negedge clk);
    req_read       = 3'b001;
    req_address[0] = 4'd4;
    read_valid     = 1'b1;
    data_out       = 32'h11;
    #1;
    chk("pipe2_addr", address, 4'd4);
    chk("pipe_resp0", req_read_valid, 3'b001);
    @(negedge clk);
    set_idle();
    read_valid = 1'b1;
    data_out   = 32'h22;
    #1;
    chk("pipe_resp1", req_read_valid, 3'b010);
    chk("pipe_rdata1", req_data_out, 32'h22);
    @(negedge clk);
    read_valid = 1'b1;
    data_out   = 32'h33;
    #1;
    chk("pipe_resp2", req_read_valid, 3'b001);
    @(negedge clk);
    set_idle();
    #1;
    chk("pipe_resp_end", req_read_valid, 3'b000);
    chk("pipe_tagerr", tag_error, 1'b0);

    // Read+write together: only write issued, no tag pushed.
    @(negedge clk);
    req_read       = 3'b001;
    req_write      = 3'b001;
    req_address[0] = 4'd5;
    req_data_in[0] = 32'h1234;
    #1;
    chk("rw_write", write, 1'b1);
    chk("rw_read", read, 1'b0);
    chk("rw_addr", address, 4'd5);
    chk("rw_data", data_in, 32'h1234);
    @(negedge clk);
    set_idle();
    #1;
    chk("rw_rvalid", req_read_valid, 3'b000);
    // Spurious response in the slot the dropped read would have used.
    @(negedge clk);
    read_valid = 1'b1;
    data_out   = 32'hBAD;
    #1;
    chk("spur_rvalid", req_read_valid, 3'b000);
    chk("spur_tagerr_pre", tag_error, 1'b0);
    @(negedge clk);
    set_idle();
    #1;
    chk("spur_tagerr", tag_error, 1'b1);
    @(negedge clk);
    #1;
    chk("spur_tagerr_sticky", tag_error, 1'b1);

    // Reset mid-read: rr_ptr would be 2 after this grant; reset returns it to 0.
    @(negedge clk);
    req_read       = 3'b010;
    req_address[1] = 4'd7;
    #1;
    chk("rmid_read", read, 1'b1);
    chk("rmid_addr", address, 4'd7);
    @(negedge clk);
    set_idle();
    reset          = 1'b0;
    req_write      = 3'b101;
    req_address[0] = 4'hC;
    req_address[2] = 4'hE;
    #1;
    chk("rmid_wait", req_waitrequest, 3'b101);
    chk("rmid_write", write, 1'b0);
    chk("rmid_addr_clr", address, 4'h0);
    chk("rmid_tagerr_clr", tag_error, 1'b0);
    @(negedge clk);
    reset      = 1'b1;
    read_valid = 1'b1;
    data_out   = 32'h77;
    #1;
    chk("rmid_rvalid", req_read_valid, 3'b000);
    chk("rmid_wait_post", req_waitrequest, 3'b100);
    chk("rmid_addr_post", address, 4'hC);
    @(negedge clk);
    set_idle();
    #1;
    chk("rmid_tagerr", tag_error, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_bus_arbiter.md
# register_bus_arbiter

Round-robin arbiter that shares the single register-adapter command port of the I2C master peripheral between several bus requesters, for example a host Avalon slave port and an on-chip init/DMA sequencer. It grants at most one read or write per cycle, forwards it unmodified to the register adapter, and tags each read so that the adapter's fixed-latency `read_valid` is returned to the requester that issued it. Sits directly upstream of the Avalon register adapter, in the same clock domain.

## Interface
- `REQUESTERS`, 2: number of requester ports, 2..8.
- `LATENCY`, 1: read latency of the downstream adapter (`read` to `read_valid`, in cycles), ≥1.
- `ADDRESSWIDTH`, 4: register address width.
- `IDWIDTH`, `$clog2(REQUESTERS)`: requester index width (derived; do not override).

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  reset; asynchronous assert, active-low, synchronous deassert supplied externally.
- `req_read`  in  [REQUESTERS]  per-requester read command.
- `req_write`  in  [REQUESTERS]  per-requester write command.
- `req_address`  in  [REQUESTERS][ADDRESSWIDTH]  per-requester address.
- `req_data_in`  in  [REQUESTERS][32]  per-requester write data.
- `req_waitrequest`  out  [REQUESTERS]  command not accepted this cycle; hold it.
- `req_read_valid`  out  [REQUESTERS]  read data valid for this requester.
- `req_data_out`  out  [32]  read data, broadcast to all requesters.
- `read`, `write`  out  1  command to the adapter.
- `address`  out  ADDRESSWIDTH  to the adapter.
- `data_in`  out  32  write data to the adapter.
- `read_valid`  in  1  from the adapter.
- `data_out`  in  32  from the adapter.
- `tag_error`  out  1  sticky; `read_valid` arrived with no matching outstanding read.

## Operation
- Each requester is active when `req_read[i] | req_write[i]`.
- Grant is combinational. The grant goes to the first active requester found scanning upward from `rr_ptr`, wrapping modulo `REQUESTERS`.
- The granted requester's command, address and data drive `read`, `write`, `address` and `data_in` in the same cycle.
- `req_waitrequest[i]` = active and not granted. A granted requester always sees 0.
- When no requester is active: `read` = `write` = 0, and `address` and `data_in` hold the previous granted values (registered hold).
- Write precedence: if a granted requester asserts both read and write, only `write` is issued. The read is dropped (consumed) and no tag is pushed.
- `rr_ptr` (IDWIDTH bits) updates on every grant to (granted index + 1) mod `REQUESTERS`. The wrap from `REQUESTERS-1` goes to 0, which also covers non-power-of-2 counts. With no grant, `rr_ptr` holds.
- Tag pipeline: a shift register of `LATENCY` stages, each stage holding {valid, id}.
  - Stage 0 loads {issued read, granted id} every cycle.
  - Stages shift every cycle unconditionally.
  - The stage at index `LATENCY-1` is the matching tag for the current `read_valid`.
- Return path: `req_read_valid[id]` = `read_valid` & tag.valid, and all other bits are 0. `req_data_out` = `data_out` (combinational pass-through).
- If `read_valid` = 1 while tag.valid = 0, set `tag_error` (sticky until reset) and assert no `req_read_valid` bit.
- If tag.valid = 1 while `read_valid` = 0, the response is lost. No flag is raised because the adapter never does this.
- Back-to-back reads from different requesters every cycle are fully pipelined, with no bubbles.

## Timing
- Command path: 0 cycles, combinational from `req_*` to the adapter port.
- Read response: `req_read_valid` asserts exactly `LATENCY` cycles after the cycle in which that requester's read was granted. It is combinational from `read_valid`.
- Throughput: 1 command per cycle in aggregate. With all requesters continuously active, each requester gets 1 grant per `REQUESTERS` cycles.
- Reset values (while `reset` = 0):
  - `rr_ptr` = 0, all tags invalid, `tag_error` = 0.
  - Held `address` and `data_in` = 0.
  - `read` = `write` = 0, `req_read_valid` = 0.
  - `req_waitrequest[i]` = active, so every active requester stalls.
- Reset mid-operation: outstanding tags are discarded. A `read_valid` arriving after reset with empty tags sets `tag_error`.
- First cycle after reset deassertion: arbitration resumes from requester 0.

## Test plan
- Single requester: with `LATENCY`=1, requester 1 reads addr 3 while the adapter returns 0xA5A5_0003 one cycle later → `read`=1, `address`=3, `req_waitrequest[1]`=0; next cycle `req_read_valid`=2'b10 and `req_data_out`=0xA5A5_0003.
- Contention: both requesters write continuously for 4 cycles from reset → grants go 0,1,0,1; each `req_waitrequest` toggles 0/1 out of phase; `rr_ptr` sequence is 1,0,1,0.
- Pipelined routing: with `LATENCY`=3, reads are granted to ids 0,1,0 on consecutive cycles → `req_read_valid` pulses 3,4,5 cycles later to ids 0,1,0 in order.
- Read+write together: requester 0 asserts both with addr 5 and data 0x1234 → `write`=1, `read`=0, no `req_read_valid` afterwards, `tag_error` stays 0.
- Spurious response: `read_valid` pulsed with no read issued → `tag_error`=1 and remains 1; all `req_read_valid`=0.
- Reset mid-read: with `LATENCY`=2, pulse `reset` low for 1 cycle after issuing a read → that read's `read_valid` is not routed, `tag_error`=1, `rr_ptr`=0.
